winograd_tile_conv_engine: RTL
==============================

Name: winograd_tile_conv_engine

Overview:
Parametrised successor of the 4x4 Winograd convolution core. It takes one already-formed 4x4 input window per channel as a single transaction and streams pre-transformed 4x4 kernels through it, kernel-major and channel-minor. For each kernel it accumulates the 2x2 Winograd tile over all channels plus the bias, then emits either the raw tile or a max-pooled, ReLU'd scalar. It sits between the per-channel window buffers and the next layer, using valid/ready handshakes on every interface.

Parameters:
DATA_WIDTH, 32, signed fixed-point word width
FRAC_WIDTH, 16, fractional bits
N_CHANNELS, 3, input channels per window (>=1)
N_KERNELS, 64, kernels applied to each window (>=1)
POOL_MODE, 1, 0 = emit 2x2 tile unpooled; 1 = emit relu(max of 4) in lane 0
SATURATE, 1, 1 = clamp the accumulator to the DATA_WIDTH range at emit; 0 = wrap

Ports:
clock_i  in  1  clock
reset_i  in  1  async active-high reset
window_valid_i  in  1  window transaction valid
window_ready_o  out  1  engine can accept a window
window_i  in  N_CHANNELS*16*DATA_WIDTH  4x4 window per channel, channel-major
kernel_valid_i  in  1  kernel beat valid
kernel_ready_o  out  1  engine consumes a kernel beat
kernel_i  in  16*DATA_WIDTH  transformed kernel for the current (kernel, channel)
bias_i  in  DATA_WIDTH  bias of the current kernel; sampled on the channel-0 beat
out_valid_o  out  1  result valid
out_ready_i  in  1  downstream accepts result
out_data_o  out  4*DATA_WIDTH  tile lanes 0..3; in pool mode lane 0 = result, lanes 1..3 = 0
out_kernel_o  out  clog2(N_KERNELS)+1  kernel index of the result
out_last_o  out  1  result belongs to the last kernel of the window
clear_overflow_i  in  1  clears overflow_o synchronously
overflow_o  out  1  sticky: Winograd-kernel overflow or saturation event

Behaviour:
- Reset is asynchronous, active-high, on reset_i; clock is clock_i.
- Reset values: state IDLE; out_valid_o, out_last_o and overflow_o at 0; out_data_o, out_kernel_o, the counters and the accumulators at 0. Reset mid-operation drops the window in flight; no partial result is emitted.
- FSM IDLE -> ACCUM -> EMIT.
- IDLE:
  - window_ready_o = 1.
  - On window_valid_i, register window_i, clear the channel and kernel counters, go to ACCUM.
- ACCUM:
  - kernel_ready_o = 1; each beat with kernel_valid_i feeds window[ch] and kernel_i to the combinational Winograd kernel.
  - ch==0: acc[i] = sext(bias_i) + res[i].
  - ch>0: acc[i] += res[i].
  - The accumulator is DATA_WIDTH+clog2(N_CHANNELS)+1 bits, so no internal wrap occurs.
  - No beat: hold. After the beat with ch==N_CHANNELS-1, go to EMIT.
- EMIT:
  - Registered outputs are formed on entry: saturate or wrap each lane, then optionally pool and ReLU.
  - out_valid_o stays high and all outputs stay stable until out_ready_i.
  - On the handshake: if kernel==N_KERNELS-1, go to IDLE; otherwise kernel++, ch=0, go to ACCUM.
- Latency: the first result is valid N_CHANNELS+1 cycles after window acceptance with back-to-back kernel beats. Minimum period is N_KERNELS*(N_CHANNELS+1)+1 cycles per window.
- Saturation with SATURATE=1: lanes above the maximum clamp to 2^(DW-1)-1 and lanes below the minimum clamp to -2^(DW-1); either case sets overflow_o. Any beat with the kernel overflow flag also sets overflow_o.
- overflow_o simultaneous events: if clear_overflow_i coincides with a new overflow event, the set wins.
- window_ready_o and kernel_ready_o are both 0 in EMIT. kernel_valid_i is ignored outside ACCUM.
- N_CHANNELS==1: ACCUM lasts exactly one accepted beat.

Decomposition:
- Package winograd_pkg: tile size constant 4, window size 16, state enum, and saturate and relu helper functions.
- Reused sub-module: winograd_4x4_conv_kernel, one instance muxed by the channel counter.
- Natural new sub-module: tile_postproc (saturate, max-pool, ReLU; combinational, registered in the engine).

Test Plan:
- All kernels 0, bias 0x0001_8000, N_CHANNELS=3, N_KERNELS=2, POOL_MODE=0 -> 2 results, every lane 0x0001_8000, out_kernel_o = 0 then 1, out_last_o only on the second.
- Same stimulus with POOL_MODE=1 and bias 0xFFFF_0000 (-1.0) -> lane 0 = 0 (ReLU), lanes 1..3 = 0.
- Random window and kernels, 3 channels, POOL_MODE=0 -> lanes match a golden model of bias plus the sum of Winograd tiles bit-exactly; first out_valid_o exactly 4 cycles after window accept.
- Bias 0x7FFF_0000 with kernel and window giving a positive tile, SATURATE=1 -> lane = 0x7FFF_FFFF, overflow_o = 1, cleared the cycle after clear_overflow_i.
- out_ready_i low for 5 cycles in EMIT, with kernel_valid_i high and window_valid_i high -> outputs stable, kernel_ready_o = 0, window_ready_o = 0; the next beat is consumed only after the handshake.
- reset_i asserted mid-ACCUM (ch=1) -> out_valid_o = 0 immediately, window_ready_o = 1 after release; the next window produces correct results with no residue from the aborted one.

Source files
------------

// File: rtl/winograd_pkg.sv
// Shared constants, FSM state type and arithmetic helpers for the Winograd
// tile convolution engine.
package winograd_pkg;

   localparam int unsigned TILE_SIZE = 4;   // window edge length
   localparam int unsigned WIN_SIZE  = 16;  // words per 4x4 window / kernel
   localparam int unsigned LANES     = 4;   // 2x2 output tile lanes
   localparam int unsigned WIDE_W    = 128; // working width for the helpers

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ACCUM = 2'd1,
      ST_EMIT  = 2'd2
   } state_e;

   // Clamp x to the signed dw-bit range; clipped flags that a clamp happened.
   function automatic logic signed [WIDE_W-1:0] sat_wide(
      input  logic signed [WIDE_W-1:0] x,
      input  int unsigned              dw,
      output logic                     clipped
   );
      logic signed [WIDE_W-1:0] hi;
      logic signed [WIDE_W-1:0] lo;
      hi      = WIDE_W'((WIDE_W'(1) << (dw - 1)) - WIDE_W'(1));
      lo      = ~hi;
      clipped = 1'b0;
      if (x > hi) begin
         clipped = 1'b1;
         return hi;
      end
      if (x < lo) begin
         clipped = 1'b1;
         return lo;
      end
      return x;
   endfunction

   // Rectified linear unit.
   function automatic logic signed [WIDE_W-1:0] relu_wide(
      input logic signed [WIDE_W-1:0] x
   );
      return x[WIDE_W-1] ? '0 : x;
   endfunction

endpackage

// File: rtl/tile_postproc.sv
// Combinational post-processing of the accumulated tile: saturate or wrap
// each lane to DATA_WIDTH, then optionally max-pool the four lanes and ReLU.
// Ports: acc_i   four ACC_WIDTH accumulator lanes
//        data_o  four DATA_WIDTH lanes (pool mode: lane 0 only, rest 0)
//        sat_o   at least one lane was clamped
module tile_postproc
   import winograd_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned ACC_WIDTH  = 35,
   parameter int unsigned POOL_MODE  = 1,
   parameter int unsigned SATURATE   = 1
) (
   input  logic [LANES*ACC_WIDTH-1:0]  acc_i,
   output logic [LANES*DATA_WIDTH-1:0] data_o,
   output logic                        sat_o
);

   logic signed [WIDE_W-1:0]     wide;
   logic                         clip;
   logic signed [DATA_WIDTH-1:0] lane [LANES];
   logic signed [DATA_WIDTH-1:0] mx;

   // Narrow each lane, then pool the narrowed lanes.
   always_comb begin
      data_o = '0;
      sat_o  = 1'b0;
      clip   = 1'b0;
      wide   = '0;
      for (int j = 0; j < LANES; j++) begin
         wide = WIDE_W'(signed'(acc_i[j*ACC_WIDTH +: ACC_WIDTH]));
         if (SATURATE != 0) begin
            wide  = sat_wide(wide, DATA_WIDTH, clip);
            sat_o = sat_o | clip;
         end
         lane[j] = wide[DATA_WIDTH-1:0];
      end
      mx = lane[0];
      for (int j = 1; j < LANES; j++) begin
         if (lane[j] > mx) begin
            mx = lane[j];
         end
      end
      if (POOL_MODE != 0) begin
         data_o[DATA_WIDTH-1:0] = DATA_WIDTH'(relu_wide(WIDE_W'(mx)));
      end else begin
         for (int j = 0; j < LANES; j++) begin
            data_o[j*DATA_WIDTH +: DATA_WIDTH] = lane[j];
         end
      end
   end

endmodule

// File: rtl/winograd_4x4_conv_kernel.sv
// Combinational Winograd F(2x2,3x3) core: Y = A^T [(B^T d B) .* U] A.
// Ports: window_i  4x4 input window d, word i = row*4+col
//        kernel_i  4x4 pre-transformed kernel U, same layout
//        tile_o    2x2 result, lanes y00,y01,y10,y11 (wrapped to DATA_WIDTH)
//        overflow_o  any lane exceeded the signed DATA_WIDTH range
// Products are rescaled by an arithmetic right shift (floor) of FRAC_WIDTH.
module winograd_4x4_conv_kernel
   import winograd_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned FRAC_WIDTH = 16
) (
   input  logic [WIN_SIZE*DATA_WIDTH-1:0] window_i,
   input  logic [WIN_SIZE*DATA_WIDTH-1:0] kernel_i,
   output logic [LANES*DATA_WIDTH-1:0]    tile_o,
   output logic                           overflow_o
);

   localparam int unsigned VW = DATA_WIDTH + 2;  // input transform growth
   localparam int unsigned PW = VW + DATA_WIDTH; // full product
   localparam int unsigned YW = PW + 4;          // output transform growth

   logic signed [VW-1:0]         d [WIN_SIZE];
   logic signed [VW-1:0]         t [WIN_SIZE];
   logic signed [VW-1:0]         v [WIN_SIZE];
   logic signed [DATA_WIDTH-1:0] u [WIN_SIZE];
   logic signed [PW-1:0]         m [WIN_SIZE];
   logic signed [YW-1:0]         r [2*TILE_SIZE];
   logic signed [YW-1:0]         y [LANES];
   logic [YW-DATA_WIDTH:0]       top;

   // Input transform, element-wise product, output transform.
   always_comb begin
      tile_o     = '0;
      overflow_o = 1'b0;
      top        = '0;
      for (int i = 0; i < WIN_SIZE; i++) begin
         d[i] = VW'(signed'(window_i[i*DATA_WIDTH +: DATA_WIDTH]));
         u[i] = signed'(kernel_i[i*DATA_WIDTH +: DATA_WIDTH]);
      end
      for (int c = 0; c < TILE_SIZE; c++) begin
         t[c]      = d[c] - d[8+c];
         t[4+c]    = d[4+c] + d[8+c];
         t[8+c]    = d[8+c] - d[4+c];
         t[12+c]   = d[4+c] - d[12+c];
      end
      for (int rr = 0; rr < TILE_SIZE; rr++) begin
         v[rr*4+0] = t[rr*4+0] - t[rr*4+2];
         v[rr*4+1] = t[rr*4+1] + t[rr*4+2];
         v[rr*4+2] = t[rr*4+2] - t[rr*4+1];
         v[rr*4+3] = t[rr*4+1] - t[rr*4+3];
      end
      for (int i = 0; i < WIN_SIZE; i++) begin
         m[i] = (PW'(v[i]) * PW'(u[i])) >>> FRAC_WIDTH;
      end
      for (int c = 0; c < TILE_SIZE; c++) begin
         r[c]   = YW'(m[c]) + YW'(m[4+c]) + YW'(m[8+c]);
         r[4+c] = YW'(m[4+c]) - YW'(m[8+c]) - YW'(m[12+c]);
      end
      for (int rr = 0; rr < 2; rr++) begin
         y[rr*2+0] = r[rr*4+0] + r[rr*4+1] + r[rr*4+2];
         y[rr*2+1] = r[rr*4+1] - r[rr*4+2] - r[rr*4+3];
      end
      // A lane fits when every bit above the sign position copies the sign.
      for (int j = 0; j < LANES; j++) begin
         tile_o[j*DATA_WIDTH +: DATA_WIDTH] = y[j][DATA_WIDTH-1:0];
         top = y[j][YW-1:DATA_WIDTH-1];
         if (!((&top) || (~|top))) begin
            overflow_o = 1'b1;
         end
      end
   end

endmodule

// File: rtl/winograd_tile_conv_engine.sv
// Winograd tile convolution engine: latches one multi-channel 4x4 window,
// streams pre-transformed kernels through it (kernel-major, channel-minor),
// accumulates bias plus per-channel 2x2 tiles and emits one result per kernel.
// Ports: clock_i/reset_i        clock, async active-high reset
//        window_*               window transaction (accepted in IDLE)
//        kernel_*/bias_i        kernel beats (consumed in ACCUM)
//        out_*                  registered result held until out_ready_i
//        clear_overflow_i       synchronous clear of the sticky overflow_o
module winograd_tile_conv_engine
   import winograd_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned FRAC_WIDTH = 16,
   parameter int unsigned N_CHANNELS = 3,
   parameter int unsigned N_KERNELS  = 64,
   parameter int unsigned POOL_MODE  = 1,
   parameter int unsigned SATURATE   = 1
) (
   input  logic                                      clock_i,
   input  logic                                      reset_i,
   input  logic                                      window_valid_i,
   output logic                                      window_ready_o,
   input  logic [N_CHANNELS*WIN_SIZE*DATA_WIDTH-1:0] window_i,
   input  logic                                      kernel_valid_i,
   output logic                                      kernel_ready_o,
   input  logic [WIN_SIZE*DATA_WIDTH-1:0]            kernel_i,
   input  logic [DATA_WIDTH-1:0]                     bias_i,
   output logic                                      out_valid_o,
   input  logic                                      out_ready_i,
   output logic [LANES*DATA_WIDTH-1:0]               out_data_o,
   output logic [$clog2(N_KERNELS):0]                out_kernel_o,
   output logic                                      out_last_o,
   input  logic                                      clear_overflow_i,
   output logic                                      overflow_o
);

   localparam int unsigned KW    = $clog2(N_KERNELS) + 1;
   localparam int unsigned CH_W  = $clog2(N_CHANNELS) + 1;
   localparam int unsigned AW    = DATA_WIDTH + $clog2(N_CHANNELS) + 1;
   localparam int unsigned WIN_W = WIN_SIZE * DATA_WIDTH;

   state_e                          state_q;
   state_e                          state_d;
   logic [N_CHANNELS*WIN_W-1:0]     win_q;
   logic [CH_W-1:0]                 ch_q;
   logic [KW-1:0]                   kern_q;
   logic [LANES*AW-1:0]             acc_q;
   logic [LANES*AW-1:0]             acc_d;
   logic [WIN_W-1:0]                win_sel;
   logic [LANES*DATA_WIDTH-1:0]     tile_res;
   logic [LANES*DATA_WIDTH-1:0]     pp_data;
   logic                            kern_ovf;
   logic                            sat_evt;
   logic                            beat;
   logic                            last_ch;
   logic                            last_kern;
   logic                            ovf_set;

   assign beat      = (state_q == ST_ACCUM) && kernel_valid_i;
   assign last_ch   = (ch_q == CH_W'(N_CHANNELS - 1));
   assign last_kern = (kern_q == KW'(N_KERNELS - 1));
   assign ovf_set   = beat && (kern_ovf || (last_ch && sat_evt));

   // Channel mux in front of the single Winograd core.
   always_comb begin
      win_sel = '0;
      for (int c = 0; c < N_CHANNELS; c++) begin
         if (ch_q == CH_W'(c)) begin
            win_sel = win_q[c*WIN_W +: WIN_W];
         end
      end
   end

   winograd_4x4_conv_kernel #(
      .DATA_WIDTH (DATA_WIDTH),
      .FRAC_WIDTH (FRAC_WIDTH)
   ) u_kernel (
      .window_i   (win_sel),
      .kernel_i   (kernel_i),
      .tile_o     (tile_res),
      .overflow_o (kern_ovf)
   );

   // Channel 0 restarts from the bias, later channels add on top.
   always_comb begin
      acc_d = '0;
      for (int j = 0; j < LANES; j++) begin
         if (ch_q == '0) begin
            acc_d[j*AW +: AW] = AW'(signed'(bias_i))
                              + AW'(signed'(tile_res[j*DATA_WIDTH +: DATA_WIDTH]));
         end else begin
            acc_d[j*AW +: AW] = acc_q[j*AW +: AW]
                              + AW'(signed'(tile_res[j*DATA_WIDTH +: DATA_WIDTH]));
         end
      end
   end

   // Post-processing sees the value the accumulator takes on this beat, so
   // the result is registered in the same edge that enters EMIT.
   tile_postproc #(
      .DATA_WIDTH (DATA_WIDTH),
      .ACC_WIDTH  (AW),
      .POOL_MODE  (POOL_MODE),
      .SATURATE   (SATURATE)
   ) u_postproc (
      .acc_i  (acc_d),
      .data_o (pp_data),
      .sat_o  (sat_evt)
   );

   // State register.
   always_ff @(posedge clock_i or posedge reset_i) begin
      if (reset_i) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic.
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: begin
            if (window_valid_i) begin
               state_d = ST_ACCUM;
            end
         end
         ST_ACCUM: begin
            if (beat && last_ch) begin
               state_d = ST_EMIT;
            end
         end
         ST_EMIT: begin
            if (out_ready_i) begin
               state_d = last_kern ? ST_IDLE : ST_ACCUM;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // Handshake outputs decoded from state.
   always_comb begin
      window_ready_o = 1'b0;
      kernel_ready_o = 1'b0;
      case (state_q)
         ST_IDLE:  window_ready_o = 1'b1;
         ST_ACCUM: kernel_ready_o = 1'b1;
         default: begin
            window_ready_o = 1'b0;
            kernel_ready_o = 1'b0;
         end
      endcase
   end

   // Datapath registers; set of overflow wins over a coincident clear.
   always_ff @(posedge clock_i or posedge reset_i) begin
      if (reset_i) begin
         win_q        <= '0;
         ch_q         <= '0;
         kern_q       <= '0;
         acc_q        <= '0;
         out_valid_o  <= 1'b0;
         out_data_o   <= '0;
         out_kernel_o <= '0;
         out_last_o   <= 1'b0;
         overflow_o   <= 1'b0;
      end else begin
         overflow_o <= (overflow_o && !clear_overflow_i) || ovf_set;
         case (state_q)
            ST_IDLE: begin
               if (window_valid_i) begin
                  win_q  <= window_i;
                  ch_q   <= '0;
                  kern_q <= '0;
               end
            end
            ST_ACCUM: begin
               if (beat) begin
                  acc_q <= acc_d;
                  if (last_ch) begin
                     out_valid_o  <= 1'b1;
                     out_data_o   <= pp_data;
                     out_kernel_o <= kern_q;
                     out_last_o   <= last_kern;
                  end else begin
                     ch_q <= ch_q + CH_W'(1);
                  end
               end
            end
            ST_EMIT: begin
               if (out_ready_i) begin
                  out_valid_o <= 1'b0;
                  out_last_o  <= 1'b0;
                  ch_q        <= '0;
                  if (!last_kern) begin
                     kern_q <= kern_q + KW'(1);
                  end
               end
            end
            default: begin
               ch_q <= '0;
            end
         endcase
      end
   end

endmodule
